perceptron_train_ctrl: RTL and testbench
========================================

Name: perceptron_train_ctrl

Overview:
Training-side companion to the perceptron predictor. It holds the speculative global history used as the predictor's feature vector and records every issued prediction in an in-order queue. When each branch resolves, it replays the recorded PC, feature snapshot and outcome to the predictor's train port. On a mispredict or pipeline flush it restores history from the committed copy; it sits between fetch (predict side) and execute (resolve side).

Parameters:
FEATURES, 32, history length; width of feature vector and GHR
DEPTH, 8, in-flight prediction queue entries; power of 2, at least 2
CONF_W, 16, width of stored predictor confidence
THETA, 24, training threshold magnitude; used only with PTC_TRAIN_THRESH_EN

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
pred_valid  in  1  fetch issued a branch prediction this cycle
pred_pc  in  32  PC of predicted branch
pred_taken  in  1  predictor's prediction output
pred_conf  in  CONF_W  predictor's confidence output (signed)
pred_ready  out  1  queue not full; a push is accepted only when pred_valid && pred_ready
predict_features  out  FEATURES  speculative GHR, driven to the predictor
resolve_valid  in  1  oldest in-flight branch resolved
resolve_pc  in  32  PC of resolved branch
resolve_taken  in  1  actual direction
flush  in  1  pipeline flush (exception/redirect); drops all in-flight entries
train_en  out  1  one-cycle train strobe
train_pc  out  32  PC to train
train_features  out  FEATURES  history snapshot taken at prediction time
actual_taken  out  1  outcome to train
mispredict  out  1  one-cycle pulse: resolved direction differed from recorded prediction
sync_err  out  1  one-cycle pulse: resolve with empty queue or PC mismatch
occupancy  out  log2(DEPTH)+1  entries in flight

Behaviour:
- Reset (async, rst=1): queue empty, spec_ghr=arch_ghr=0, all outputs 0, pred_ready=1.
- Entry = {pc, ghr_snapshot (spec_ghr before the shift), pred_taken, pred_conf}. Circular buffer with rd/wr pointers plus a count.
- Push: pred_valid && pred_ready pushes the entry and sets spec_ghr <= {spec_ghr[FEATURES-2:0], pred_taken}.
- pred_ready = (count != DEPTH), derived from registered state only. A pop in the same cycle does not free a slot for a push.
- Resolve with a non-empty queue and resolve_pc == head pc:
  - pop the head; arch_ghr <= {arch_ghr[FEATURES-2:0], resolve_taken}.
  - Next cycle: train_en=1, train_pc=head pc, train_features=head snapshot, actual_taken=resolve_taken. Latency is exactly 1 cycle.
  - mispredict pulses in that same cycle if resolve_taken != stored pred_taken.
- Mispredict recovery (same edge as the pop): all remaining entries discarded (count=0); spec_ghr <= updated arch_ghr value.
- Resolve with an empty queue, or with a PC mismatch: no pop, no train. sync_err pulses next cycle. Recovery is the same as flush. arch_ghr is unchanged.
- flush: count=0, pointers equalised, spec_ghr <= arch_ghr (including any same-cycle resolve update).
- Simultaneous events:
  - resolve+flush: the resolve is processed and trained, then the flush clears the rest.
  - push+mispredict, push+flush, push+sync_err: the push is dropped, as wrong-path.
  - push+valid resolve without mispredict: both occur; count is unchanged.
- Pointer wrap is modulo DEPTH. occupancy is the registered count.
- train_en, mispredict and sync_err are single-cycle and registered. train_* data holds its value when train_en=0.
- Reset mid-operation aborts everything immediately, including a pending train_en.

Optional Feature:
PTC_TRAIN_THRESH_EN:
- Defined: train_en fires only if the branch mispredicted or |stored pred_conf| <= THETA. Confident correct predictions are not trained. The pop, arch_ghr update and mispredict pulse are unchanged.
- Undefined: every valid resolve trains; pred_conf is neither stored nor used, and its storage is removed.

Decomposition:
- Package ptc_pkg: entry struct (pc, snapshot, taken, conf), GHR shift function, pointer/count widths derived from DEPTH.
- One natural sub-module, ptc_inflight_fifo: storage, pointers, count, full/empty, a clear-all port and a single-entry head read. The top holds the GHRs, compare logic and output registers.

Test Plan:
1. Reset, then push pc=0x100 taken, resolve pc=0x100 taken -> 1 cycle later train_en=1, train_pc=0x100, train_features=0, actual_taken=1, mispredict=0; arch_ghr=1.
2. Push 3 branches (T,N,T); resolve the first as N -> mispredict=1, occupancy=0, predict_features=0x0 (arch_ghr), train_features=0x0.
3. Push 8 with DEPTH=8 -> pred_ready=0; a 9th pred_valid is ignored. Resolve+push in the same cycle -> push rejected, occupancy=7.
4. Resolve with an empty queue -> sync_err pulse, train_en=0. Resolve pc=0x204 against head 0x200 -> sync_err, queue cleared.
5. resolve and flush together with 2 entries -> train_en for the head, occupancy=0, spec_ghr equals arch_ghr. Assert rst while train is pending -> train_en stays 0.
6. With PTC_TRAIN_THRESH_EN: correct resolve at conf=100 -> no train_en; correct at conf=-10 -> train_en; mispredict at conf=100 -> train_en.

Source files
------------

// File: rtl/ptc_pkg.sv
// Shared helpers for the perceptron training controller: queue pointer and
// count widths derived from the queue depth, and the global-history shift.
package ptc_pkg;

    // Branch PCs are always 32 bits wide on both predict and resolve sides.
    localparam int unsigned PTC_PC_W    = 32;
    // Widest history the shift helper handles; callers cast down to FEATURES.
    localparam int unsigned PTC_GHR_MAX = 256;

    function automatic int unsigned ptc_ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int unsigned ptc_cnt_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    // Newest outcome enters at bit 0, oldest history bit falls off the top.
    function automatic logic [PTC_GHR_MAX-1:0] ptc_ghr_shift(
        input logic [PTC_GHR_MAX-1:0] ghr,
        input logic                   outcome
    );
        return {ghr[PTC_GHR_MAX-2:0], outcome};
    endfunction

endpackage

// File: rtl/ptc_inflight_fifo.sv
// In-order queue of in-flight predictions: circular storage with read/write
// pointers and an explicit count, a single head read port and a clear-all.
module ptc_inflight_fifo
    import ptc_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clear,
    input  logic [WIDTH-1:0]       push_data,
    output logic [WIDTH-1:0]       head_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned PTR_W = ptc_ptr_w(DEPTH);
    localparam int unsigned CNT_W = ptc_cnt_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Entry storage; no reset needed since count gates every read.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and count; clear drops every entry and equalises the pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    assign head_data = mem[rd_ptr];
    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);

endmodule

// File: rtl/perceptron_train_ctrl.sv
// Training-side companion to the perceptron predictor. Keeps the speculative
// and committed global history, records each issued prediction in order and
// replays it to the train port when the branch resolves. Mispredicts, PC
// sync errors and flushes restore speculative history from the committed one.
// Optional build macro PTC_TRAIN_THRESH_EN: only train on mispredicts or when
// the stored confidence magnitude is at or below THETA.
module perceptron_train_ctrl
    import ptc_pkg::*;
#(
    parameter int unsigned FEATURES = 32,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned CONF_W   = 16,
    parameter int unsigned THETA    = 24
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pred_valid,
    input  logic [31:0]            pred_pc,
    input  logic                   pred_taken,
    input  logic [CONF_W-1:0]      pred_conf,
    output logic                   pred_ready,
    output logic [FEATURES-1:0]    predict_features,
    input  logic                   resolve_valid,
    input  logic [31:0]            resolve_pc,
    input  logic                   resolve_taken,
    input  logic                   flush,
    output logic                   train_en,
    output logic [31:0]            train_pc,
    output logic [FEATURES-1:0]    train_features,
    output logic                   actual_taken,
    output logic                   mispredict,
    output logic                   sync_err,
    output logic [$clog2(DEPTH):0] occupancy
);

    typedef struct packed {
        logic [PTC_PC_W-1:0] pc;
        logic [FEATURES-1:0] snap;
        logic                taken;
`ifdef PTC_TRAIN_THRESH_EN
        logic [CONF_W-1:0]   conf;
`endif
    } entry_t;

    entry_t              push_entry;
    entry_t              head_entry;
    logic                q_full;
    logic                q_empty;
    logic [FEATURES-1:0] spec_ghr;
    logic [FEATURES-1:0] arch_ghr;
    logic [FEATURES-1:0] arch_next;
    logic [FEATURES-1:0] spec_shift;
    logic                head_match;
    logic                res_ok;
    logic                res_bad;
    logic                mis;
    logic                clear;
    logic                push;
    logic                train_fire;

    // Resolve classification against the oldest in-flight entry.
    assign head_match = !q_empty && (head_entry.pc == resolve_pc);
    assign res_ok     = resolve_valid && head_match;
    assign res_bad    = resolve_valid && !head_match;
    assign mis        = res_ok && (resolve_taken != head_entry.taken);
    assign clear      = flush || mis || res_bad;
    // Wrong-path pushes are dropped whenever the queue is being cleared.
    assign push       = pred_valid && pred_ready && !clear;

    assign arch_next  = res_ok ? FEATURES'(ptc_ghr_shift(PTC_GHR_MAX'(arch_ghr), resolve_taken))
                               : arch_ghr;
    assign spec_shift = FEATURES'(ptc_ghr_shift(PTC_GHR_MAX'(spec_ghr), pred_taken));

    // Assemble the queue entry with the history before this branch's shift.
    always_comb begin
        push_entry       = '0;
        push_entry.pc    = pred_pc;
        push_entry.snap  = spec_ghr;
        push_entry.taken = pred_taken;
`ifdef PTC_TRAIN_THRESH_EN
        push_entry.conf  = pred_conf;
`endif
    end

`ifdef PTC_TRAIN_THRESH_EN
    logic signed [CONF_W:0] conf_ext;
    logic signed [CONF_W:0] conf_mag;
    logic                   conf_low;

    // One extra bit so the most negative confidence has a representable magnitude.
    assign conf_ext   = $signed({head_entry.conf[CONF_W-1], head_entry.conf});
    assign conf_mag   = conf_ext[CONF_W] ? -conf_ext : conf_ext;
    assign conf_low   = (conf_mag <= $signed((CONF_W+1)'(THETA)));
    assign train_fire = res_ok && (mis || conf_low);
`else
    logic unused_cfg;

    assign unused_cfg = (^pred_conf) ^ (THETA == 0);
    assign train_fire = res_ok;
`endif

    ptc_inflight_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (res_ok),
        .clear     (clear),
        .push_data (push_entry),
        .head_data (head_entry),
        .count     (occupancy),
        .full      (q_full),
        .empty     (q_empty)
    );

    assign pred_ready       = !q_full;
    assign predict_features = spec_ghr;

    // History registers; recovery restores speculative from the updated committed copy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spec_ghr <= '0;
            arch_ghr <= '0;
        end else begin
            arch_ghr <= arch_next;
            if (clear) begin
                spec_ghr <= arch_next;
            end else if (push) begin
                spec_ghr <= spec_shift;
            end
        end
    end

    // Registered one-cycle strobes and held train payload.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            train_en       <= 1'b0;
            mispredict     <= 1'b0;
            sync_err       <= 1'b0;
            train_pc       <= '0;
            train_features <= '0;
            actual_taken   <= 1'b0;
        end else begin
            train_en   <= train_fire;
            mispredict <= mis;
            sync_err   <= res_bad;
            if (train_fire) begin
                train_pc       <= head_entry.pc;
                train_features <= head_entry.snap;
                actual_taken   <= resolve_taken;
            end
        end
    end

endmodule

// File: tb/tb_perceptron_train_ctrl.sv
// Bench for perceptron_train_ctrl: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_perceptron_train_ctrl;

    localparam int FEATURES = 32;
    localparam int DEPTH    = 8;
    localparam int CONF_W   = 16;
    localparam int THETA    = 24;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   pred_valid;
    logic [31:0]            pred_pc;
    logic                   pred_taken;
    logic [CONF_W-1:0]      pred_conf;
    logic                   pred_ready;
    logic [FEATURES-1:0]    predict_features;
    logic                   resolve_valid;
    logic [31:0]            resolve_pc;
    logic                   resolve_taken;
    logic                   flush;
    logic                   train_en;
    logic [31:0]            train_pc;
    logic [FEATURES-1:0]    train_features;
    logic                   actual_taken;
    logic                   mispredict;
    logic                   sync_err;
    logic [$clog2(DEPTH):0] occupancy;

    always #5 clk = ~clk;

    perceptron_train_ctrl #(
        .FEATURES (FEATURES),
        .DEPTH    (DEPTH),
        .CONF_W   (CONF_W),
        .THETA    (THETA)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .pred_valid       (pred_valid),
        .pred_pc          (pred_pc),
        .pred_taken       (pred_taken),
        .pred_conf        (pred_conf),
        .pred_ready       (pred_ready),
        .predict_features (predict_features),
        .resolve_valid    (resolve_valid),
        .resolve_pc       (resolve_pc),
        .resolve_taken    (resolve_taken),
        .flush            (flush),
        .train_en         (train_en),
        .train_pc         (train_pc),
        .train_features   (train_features),
        .actual_taken     (actual_taken),
        .mispredict       (mispredict),
        .sync_err         (sync_err),
        .occupancy        (occupancy)
    );

    typedef struct {
        logic [31:0]        pc;
        logic [31:0]        snap;
        logic               taken;
        logic signed [15:0] conf;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_spec, m_arch, m_tpc, m_tfeat;
    logic        m_tact, m_ten, m_mis, m_sync;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic model_reset();
        q.delete();
        m_spec = '0; m_arch = '0; m_tpc = '0; m_tfeat = '0;
        m_tact = 1'b0; m_ten = 1'b0; m_mis = 1'b0; m_sync = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pred_valid = 1'b0; resolve_valid = 1'b0; flush = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    // Drive one cycle of inputs, advance the reference model, land at edge+1.
    task automatic step(input logic pv, input logic [31:0] ppc, input logic pt, input logic [15:0] pcf,
                        input logic rv, input logic [31:0] rpc, input logic rt, input logic fl);
        ent_t e;
        bit   clr, rdy;
`ifdef PTC_TRAIN_THRESH_EN
        int   mag;
`endif
        pred_valid = pv; pred_pc = ppc; pred_taken = pt; pred_conf = pcf;
        resolve_valid = rv; resolve_pc = rpc; resolve_taken = rt; flush = fl;
        rdy = (q.size() != DEPTH);
        clr = fl;
        m_ten = 1'b0; m_mis = 1'b0; m_sync = 1'b0;
        if (rv) begin
            if (q.size() != 0 && q[0].pc == rpc) begin
                e = q.pop_front();
                m_arch = {m_arch[30:0], rt};
                m_mis = (rt != e.taken);
                clr = clr | m_mis;
`ifdef PTC_TRAIN_THRESH_EN
                mag = e.conf;
                if (mag < 0) mag = -mag;
                m_ten = m_mis || (mag <= THETA);
`else
                m_ten = 1'b1;
`endif
                if (m_ten) begin
                    m_tpc = e.pc; m_tfeat = e.snap; m_tact = rt;
                end
            end else begin
                m_sync = 1'b1;
                clr = 1'b1;
            end
        end
        if (clr) begin
            q.delete();
            m_spec = m_arch;
        end else if (pv && rdy) begin
            q.push_back('{pc: ppc, snap: m_spec, taken: pt, conf: pcf});
            m_spec = {m_spec[30:0], pt};
        end
        @(posedge clk); #1;
        pred_valid = 1'b0; resolve_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pred_valid = 1'b0; pred_pc = '0; pred_taken = 1'b0; pred_conf = '0;
        resolve_valid = 1'b0; resolve_pc = '0; resolve_taken = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (train_en !== 1'b0) begin n_err++; $display("FAIL reset_train_en got=%b exp=0", train_en); end
        n_vec++; if (mispredict !== 1'b0) begin n_err++; $display("FAIL reset_mispredict got=%b exp=0", mispredict); end
        n_vec++; if (sync_err !== 1'b0) begin n_err++; $display("FAIL reset_sync_err got=%b exp=0", sync_err); end
        n_vec++; if (occupancy !== 0) begin n_err++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
        n_vec++; if (pred_ready !== 1'b1) begin n_err++; $display("FAIL reset_pred_ready got=%b exp=1", pred_ready); end
        n_vec++; if (predict_features !== 32'h0) begin n_err++; $display("FAIL reset_features got=%h exp=0", predict_features); end
        n_vec++; if (train_pc !== 32'h0) begin n_err++; $display("FAIL reset_train_pc got=%h exp=0", train_pc); end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_basic_train();
        do_reset();
        step(1'b1, 32'h100, 1'b1, 16'd5, 1'b0, 32'h0, 1'b0, 1'b0);
        n_vec++; if (occupancy !== 1) begin n_err++; $display("FAIL basic_occ_push got=%0d exp=1", occupancy); end
        n_vec++; if (predict_features !== 32'h1) begin n_err++; $display("FAIL basic_spec got=%h exp=1", predict_features); end
        n_vec++; if (train_en !== 1'b0) begin n_err++; $display("FAIL basic_early_train got=%b exp=0", train_en); end
        step(1'b0, 32'h0, 1'b0, 16'd0, 1'b1, 32'h100, 1'b1, 1'b0);
        n_vec++; if (train_en !== 1'b1) begin n_err++; $display("FAIL basic_train_en got=%b exp=1", train_en); end
        n_vec++; if (train_pc !== 32'h100) begin n_err++; $display("FAIL basic_train_pc got=%h exp=100", train_pc); end
        n_vec++; if (train_features !== 32'h0) begin n_err++; $display("FAIL basic_train_feat got=%h exp=0", train_features); end
        n_vec++; if (actual_taken !== 1'b1) begin n_err++; $display("FAIL basic_actual got=%b exp=1", actual_taken); end
        n_vec++; if (mispredict !== 1'b0) begin n_err++; $display("FAIL basic_mispredict got=%b exp=0", mispredict); end
        n_vec++; if (occupancy !== 0) begin n_err++; $display("FAIL basic_occ_pop got=%0d exp=0", occupancy); end
        // Flush exposes the committed history (arch_ghr = 1) and ends the strobe.
        step(1'b0, 32'h0, 1'b0, 16'd0, 1'b0, 32'h0, 1'b0, 1'b1);
        n_vec++; if (predict_features !== 32'h1) begin n_err++; $display("FAIL basic_arch got=%h exp=1", predict_features); end
        n_vec++; if (train_en !== 1'b0) begin n_err++; $display("FAIL basic_strobe_len got=%b exp=0", train_en); end
        n_vec++; if (train_pc !== 32'h100) begin n_err++; $display("FAIL basic_hold_pc got=%h exp=100", train_pc); end
    endtask

    task automatic test_mispredict();
        do_reset();
        step(1'b1, 32'h200, 1'b1, 16'd0, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 32'h204, 1'b0, 16'd0, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 32'h208, 1'b1, 16'd0, 1'b0, 32'h0, 1'b0, 1'b0);
        n_vec++; if (predict_features !== 32'h5) begin n_err++; $display("FAIL mis_spec_pre got=%h exp=5", predict_features); end
        n_vec++; if (occupancy !== 3) begin n_err++; $display("FAIL mis_occ_pre got=%0d exp=3", occupancy); end
        step(1'b0, 32'h0, 1'b0, 16'd0, 1'b1, 32'h200, 1'b0, 1'b0);
        n_vec++; if (mispredict !== 1'b1) begin n_err++; $display("FAIL mis_pulse got=%b exp=1", mispredict); end
        n_vec++; if (occupancy !== 0) begin n_err++; $display("FAIL mis_occ got=%0d exp=0", occupancy); end
        n_vec++; if (predict_features !== 32'h0) begin n_err++; $display("FAIL mis_spec got=%h exp=0", predict_features); end
        n_vec++; if (train_features !== 32'h0) begin n_err++; $display("FAIL mis_train_feat got=%h exp=0", train_features); end
        n_vec++; if (train_en !== 1'b1) begin n_err++; $display("FAIL mis_train_en got=%b exp=1", train_en); end
        n_vec++; if (actual_taken !== 1'b0) begin n_err++; $display("FAIL mis_actual got=%b exp=0", actual_taken); end
        step(1'b0, 32'h0, 1'b0, 16'd0, 1'b0, 32'h0, 1'b0, 1'b0);
        n_vec++; if (mispredict !== 1'b0) begin n_err++; $display("FAIL mis_pulse_len got=%b exp=0", mispredict); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 32'h300 + 32'(i * 4), 1'(i % 2), 16'd0, 1'b0, 32'h0, 1'b0, 1'b0);
        end
        n_vec++; if (pred_ready !== 1'b0) begin n_err++; $display("FAIL full_ready got=%b exp=0", pred_ready); end
        n_vec++; if (occupancy !== DEPTH) begin n_err++; $display("FAIL full_occ got=%0d exp=%0d", occupancy, DEPTH); end
        step(1'b1, 32'h3f0, 1'b1, 16'd0, 1'b0, 32'h0, 1'b0, 1'b0);
        n_vec++; if (occupancy !== DEPTH) begin n_err++; $display("FAIL full_ninth_occ got=%0d exp=%0d", occupancy, DEPTH); end
        n_vec++; if (predict_features !== 32'h55) begin n_err++; $display("FAIL full_ninth_spec got=%h exp=55", predict_features); end
        // Pop and push together while full: the push is refused.
        step(1'b1, 32'h3f4, 1'b1, 16'd0, 1'b1, 32'h300, 1'b0, 1'b0);
        n_vec++; if (occupancy !== DEPTH - 1) begin n_err++; $display("FAIL full_poppush_occ got=%0d exp=%0d", occupancy, DEPTH - 1); end
        n_vec++; if (train_en !== 1'b1) begin n_err++; $display("FAIL full_poppush_train got=%b exp=1", train_en); end
        n_vec++; if (pred_ready !== 1'b1) begin n_err++; $display("FAIL full_ready_after got=%b exp=1", pred_ready); end
        n_vec++; if (predict_features !== 32'h55) begin n_err++; $display("FAIL full_spec_after got=%h exp=55", predict_features); end
    endtask

    task automatic test_sync_err();
        do_reset();
        step(1'b0, 32'h0, 1'b0, 16'd0, 1'b1, 32'h200, 1'b1, 1'b0);
        n_vec++; if (sync_err !== 1'b1) begin n_err++; $display("FAIL sync_empty got=%b exp=1", sync_err); end
        n_vec++; if (train_en !== 1'b0) begin n_err++; $display("FAIL sync_empty_train got=%b exp=0", train_en); end
        step(1'b1, 32'h200, 1'b1, 16'd0, 1'b0, 32'h0, 1'b0, 1'b0);
        n_vec++; if (sync_err !== 1'b0) begin n_err++; $display("FAIL sync_pulse_len got=%b exp=0", sync_err); end
        step(1'b0, 32'h0, 1'b0, 16'd0, 1'b1, 32'h204, 1'b1, 1'b0);
        n_vec++; if (sync_err !== 1'b1) begin n_err++; $display("FAIL sync_pc got=%b exp=1", sync_err); end
        n_vec++; if (train_en !== 1'b0) begin n_err++; $display("FAIL sync_pc_train got=%b exp=0", train_en); end
        n_vec++; if (occupancy !== 0) begin n_err++; $display("FAIL sync_pc_occ got=%0d exp=0", occupancy); end
        n_vec++; if (predict_features !== 32'h0) begin n_err++; $display("FAIL sync_pc_spec got=%h exp=0", predict_features); end
    endtask

    task automatic test_flush_resolve();
        do_reset();
        step(1'b1, 32'h400, 1'b1, 16'd0, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 32'h404, 1'b0, 16'd0, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 16'd0, 1'b1, 32'h400, 1'b1, 1'b1);
        n_vec++; if (train_en !== 1'b1) begin n_err++; $display("FAIL flres_train got=%b exp=1", train_en); end
        n_vec++; if (train_pc !== 32'h400) begin n_err++; $display("FAIL flres_pc got=%h exp=400", train_pc); end
        n_vec++; if (occupancy !== 0) begin n_err++; $display("FAIL flres_occ got=%0d exp=0", occupancy); end
        n_vec++; if (predict_features !== 32'h1) begin n_err++; $display("FAIL flres_spec got=%h exp=1", predict_features); end
        n_vec++; if (mispredict !== 1'b0) begin n_err++; $display("FAIL flres_mis got=%b exp=0", mispredict); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        step(1'b1, 32'h500, 1'b1, 16'd0, 1'b0, 32'h0, 1'b0, 1'b0);
        resolve_valid = 1'b1; resolve_pc = 32'h500; resolve_taken = 1'b1;
        #2 rst = 1'b1;
        @(posedge clk); #1;
        n_vec++; if (train_en !== 1'b0) begin n_err++; $display("FAIL rstmid_train got=%b exp=0", train_en); end
        n_vec++; if (occupancy !== 0) begin n_err++; $display("FAIL rstmid_occ got=%0d exp=0", occupancy); end
        n_vec++; if (predict_features !== 32'h0) begin n_err++; $display("FAIL rstmid_spec got=%h exp=0", predict_features); end
        rst = 1'b0; resolve_valid = 1'b0;
        model_reset();
        step(1'b1, 32'h504, 1'b1, 16'd0, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 16'd0, 1'b1, 32'h504, 1'b1, 1'b0);
        n_vec++; if (train_en !== 1'b1) begin n_err++; $display("FAIL rstasync_pre got=%b exp=1", train_en); end
        #1 rst = 1'b1;
        #1;
        n_vec++; if (train_en !== 1'b0) begin n_err++; $display("FAIL rstasync_train got=%b exp=0", train_en); end
        n_vec++; if (train_pc !== 32'h0) begin n_err++; $display("FAIL rstasync_pc got=%h exp=0", train_pc); end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_threshold();
        int   confs[8] = '{100, -10, 100, 24, 25, -24, -25, -32768};
        bit   miss[8]  = '{0, 0, 1, 0, 0, 0, 0, 0};
`ifdef PTC_TRAIN_THRESH_EN
        bit   exp_t[8] = '{0, 1, 1, 1, 0, 1, 0, 0};
`else
        bit   exp_t[8] = '{1, 1, 1, 1, 1, 1, 1, 1};
`endif
        do_reset();
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 32'h600, 1'b1, 16'(confs[k]), 1'b0, 32'h0, 1'b0, 1'b0);
            step(1'b0, 32'h0, 1'b0, 16'd0, 1'b1, 32'h600, !miss[k], 1'b0);
            n_vec++; if (train_en !== exp_t[k]) begin n_err++; $display("FAIL thresh_train conf=%0d got=%b exp=%b", confs[k], train_en, exp_t[k]); end
            n_vec++; if (mispredict !== miss[k]) begin n_err++; $display("FAIL thresh_mis conf=%0d got=%b exp=%b", confs[k], mispredict, miss[k]); end
        end
    endtask

    task automatic test_random();
        logic        pv, pt, rv, rt, fl;
        logic [31:0] ppc, rpc;
        logic [15:0] pcf;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            pv  = ($urandom_range(0, 9) < 6);
            ppc = 32'h1000 + 32'($urandom_range(0, 63) * 4);
            pt  = 1'($urandom_range(0, 1));
            pcf = ($urandom_range(0, 7) == 0) ? 16'($urandom()) : 16'($urandom_range(0, 80)) - 16'd40;
            rv  = ($urandom_range(0, 9) < 4);
            rpc = (q.size() != 0 && $urandom_range(0, 9) < 8) ? q[0].pc : 32'h1000 + 32'($urandom_range(0, 63) * 4);
            rt  = (q.size() != 0 && $urandom_range(0, 3) != 0) ? q[0].taken : 1'($urandom_range(0, 1));
            fl  = ($urandom_range(0, 29) == 0);
            step(pv, ppc, pt, pcf, rv, rpc, rt, fl);
            n_vec++; if (train_en !== m_ten) begin n_err++; $display("FAIL rnd_train_en cyc=%0d got=%b exp=%b", i, train_en, m_ten); end
            n_vec++; if (mispredict !== m_mis) begin n_err++; $display("FAIL rnd_mispredict cyc=%0d got=%b exp=%b", i, mispredict, m_mis); end
            n_vec++; if (sync_err !== m_sync) begin n_err++; $display("FAIL rnd_sync_err cyc=%0d got=%b exp=%b", i, sync_err, m_sync); end
            n_vec++; if (occupancy !== q.size()) begin n_err++; $display("FAIL rnd_occupancy cyc=%0d got=%0d exp=%0d", i, occupancy, q.size()); end
            n_vec++; if (pred_ready !== (q.size() != DEPTH)) begin n_err++; $display("FAIL rnd_pred_ready cyc=%0d got=%b exp=%b", i, pred_ready, q.size() != DEPTH); end
            n_vec++; if (predict_features !== m_spec) begin n_err++; $display("FAIL rnd_spec cyc=%0d got=%h exp=%h", i, predict_features, m_spec); end
            n_vec++; if (train_pc !== m_tpc) begin n_err++; $display("FAIL rnd_train_pc cyc=%0d got=%h exp=%h", i, train_pc, m_tpc); end
            n_vec++; if (train_features !== m_tfeat) begin n_err++; $display("FAIL rnd_train_feat cyc=%0d got=%h exp=%h", i, train_features, m_tfeat); end
            n_vec++; if (actual_taken !== m_tact) begin n_err++; $display("FAIL rnd_actual cyc=%0d got=%b exp=%b", i, actual_taken, m_tact); end
        end
    endtask

    initial begin
        test_reset();
        test_basic_train();
        test_mispredict();
        test_full();
        test_sync_err();
        test_flush_resolve();
        test_reset_mid();
        test_threshold();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
